// File: rtl/svm_sched_pkg.sv
// Shared types for the batch-scheduler front end: transaction payload,
// retry-queue entry and a saturating-increment helper for statistics.
package svm_sched_pkg;

   localparam int TS_W  = 16;
   localparam int ID_W  = 64;
   // Storage width for dependency bitmaps; narrower bitmaps are zero-extended
   // into it, so a stage's MAX_DEPENDENCIES must not exceed this value.
   localparam int DEP_W = 256;
   // Storage width for per-transaction retry counts (MAX_RETRIES < 2^CNT_W).
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [ID_W-1:0]  owner_programID;
      logic [DEP_W-1:0] read_dependencies;
      logic [DEP_W-1:0] write_dependencies;
   } txn_t;

   typedef struct packed {
      txn_t             txn;
      logic [CNT_W-1:0] retry_cnt;
      logic [TS_W-1:0]  ts;
   } retry_entry_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/retry_fifo.sv
// Synchronous FIFO of rejected transactions waiting out their back-off.
// The caller guarantees no push when full and no pop when empty.
module retry_fifo
   import svm_sched_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  retry_entry_t       i_push_data,
   input  logic               i_pop,
   output retry_entry_t       o_head,
   output logic [OCC_W-1:0]   o_occ
);

   retry_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Wrap-around pointers and fill count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_head = r_mem[r_rd_ptr];
   assign o_occ  = r_occ;

endmodule

// File: rtl/txn_retry_stage.sv
// Front end for the batch scheduler: one-entry output register fed either by
// a fresh transaction or by a retry whose back-off has expired. Rejected
// transactions are queued with a timestamp; those out of retries are abandoned.
module txn_retry_stage
   import svm_sched_pkg::*;
#(
   parameter  int MAX_DEPENDENCIES = 256,
   parameter  int RETRY_DEPTH      = 8,
   parameter  int MAX_RETRIES      = 15,
   parameter  int BACKOFF_CYCLES   = 16,
   localparam int RC_W  = $clog2(MAX_RETRIES + 1),
   localparam int OCC_W = $clog2(RETRY_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic [63:0]                 s_axis_tdata_owner_programID,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [63:0]                 m_axis_tdata_owner_programID,
   output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
   output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
   output logic [RC_W-1:0]             m_axis_tuser_retry_cnt,
   input  logic                        m_axis_reject,
   output logic                        abandon_valid,
   output logic [63:0]                 abandon_owner_programID,
   output logic [OCC_W-1:0]            retry_occupancy,
   output logic [31:0]                 total_retries,
   output logic [31:0]                 total_abandoned,
   output logic [31:0]                 total_forwarded
);

   txn_t             r_out;
   logic [CNT_W-1:0] r_out_cnt;
   logic             r_out_valid;
   logic [TS_W-1:0]  r_cycle_ts;
   logic             r_abandon_valid;
   logic [63:0]      r_abandon_id;
   logic [31:0]      r_tot_retries;
   logic [31:0]      r_tot_abandoned;
   logic [31:0]      r_tot_forwarded;

   txn_t             w_fresh;
   retry_entry_t     w_push_entry;
   retry_entry_t     w_head;
   logic [OCC_W-1:0] w_occ;
   logic [TS_W-1:0]  w_head_age;
   logic             w_head_eligible;
   logic             w_load_ok;
   logic             w_space_ok;
   logic             w_s_ready;
   logic             w_hs;
   logic             w_can_retry;
   logic             w_push;
   logic             w_pop;

   // Modulo-2^16 age makes eligibility correct across cycle_ts wrap.
   assign w_head_age      = r_cycle_ts - w_head.ts;
   assign w_head_eligible = (w_occ != '0) && (w_head_age >= TS_W'(BACKOFF_CYCLES));
   assign w_load_ok       = !r_out_valid || m_axis_tready;
   // Keep one FIFO slot free for whatever sits in the output register, so a
   // reject can always be queued. Depends only on registered state.
   assign w_space_ok      = (w_occ < OCC_W'(RETRY_DEPTH - 1)) ||
                            ((w_occ == OCC_W'(RETRY_DEPTH - 1)) && !r_out_valid);
   assign w_s_ready       = w_load_ok && !w_head_eligible && w_space_ok;
   assign w_hs            = r_out_valid && m_axis_tready;
   assign w_can_retry     = r_out_cnt < CNT_W'(MAX_RETRIES);
   assign w_push          = w_hs && m_axis_reject && w_can_retry;
   assign w_pop           = w_load_ok && w_head_eligible;

   // Build the fresh payload and the retry entry for the presented transaction.
   always_comb begin
      w_fresh                    = '0;
      w_fresh.owner_programID    = s_axis_tdata_owner_programID;
      w_fresh.read_dependencies  = DEP_W'(s_axis_tdata_read_dependencies);
      w_fresh.write_dependencies = DEP_W'(s_axis_tdata_write_dependencies);
      w_push_entry               = '0;
      w_push_entry.txn           = r_out;
      w_push_entry.retry_cnt     = r_out_cnt + CNT_W'(1);
      w_push_entry.ts            = r_cycle_ts;
   end

   retry_fifo #(.DEPTH(RETRY_DEPTH)) u_retry_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_occ       (w_occ)
   );

   // Free-running timestamp used to age queued retries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cycle_ts <= '0;
      else        r_cycle_ts <= r_cycle_ts + TS_W'(1);
   end

   // Output register: eligible retry first, else fresh input, else drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_cnt   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load_ok) begin
         if (w_head_eligible) begin
            r_out       <= w_head.txn;
            r_out_cnt   <= w_head.retry_cnt;
            r_out_valid <= 1'b1;
         end else if (s_axis_tvalid && w_s_ready) begin
            r_out       <= w_fresh;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // One-cycle abandon report for a rejected transaction out of retries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_abandon_valid <= 1'b0;
         r_abandon_id    <= '0;
      end else begin
         r_abandon_valid <= w_hs && m_axis_reject && !w_can_retry;
         if (w_hs && m_axis_reject && !w_can_retry) r_abandon_id <= r_out.owner_programID;
      end
   end

   // Saturating statistics on each scheduler handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tot_retries   <= '0;
         r_tot_abandoned <= '0;
         r_tot_forwarded <= '0;
      end else if (w_hs) begin
         if (!m_axis_reject)   r_tot_forwarded <= sat_inc(r_tot_forwarded);
         else if (w_can_retry) r_tot_retries   <= sat_inc(r_tot_retries);
         else                  r_tot_abandoned <= sat_inc(r_tot_abandoned);
      end
   end

   assign s_axis_tready                   = w_s_ready;
   assign m_axis_tvalid                   = r_out_valid;
   assign m_axis_tdata_owner_programID    = r_out.owner_programID;
   assign m_axis_tdata_read_dependencies  = r_out.read_dependencies[MAX_DEPENDENCIES-1:0];
   assign m_axis_tdata_write_dependencies = r_out.write_dependencies[MAX_DEPENDENCIES-1:0];
   assign m_axis_tuser_retry_cnt          = r_out_cnt[RC_W-1:0];
   assign abandon_valid                   = r_abandon_valid;
   assign abandon_owner_programID         = r_abandon_id;
   assign retry_occupancy                 = w_occ;
   assign total_retries                   = r_tot_retries;
   assign total_abandoned                 = r_tot_abandoned;
   assign total_forwarded                 = r_tot_forwarded;

endmodule

// File: doc/txn_retry_stage.md
# txn_retry_stage

Upstream front-end for the parallel batch scheduler. It accepts fresh transactions, presents them one at a time to the scheduler's AXI-Stream input, and holds any transaction the scheduler drops on a global conflict. After a fixed back-off, the held transaction is resubmitted. A transaction that exceeds a retry limit is abandoned and reported.

## Interface
Parameters:
- MAX_DEPENDENCIES, 256: width of the read and write dependency bitmaps.
- RETRY_DEPTH, 8: retry FIFO entries; must be ≥2.
- MAX_RETRIES, 15: maximum resubmissions per transaction.
- BACKOFF_CYCLES, 16: minimum cycles between a reject and its resubmission; must be <2^15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  fresh transaction handshake.
- s_axis_tdata_owner_programID  in  64  owner ID.
- s_axis_tdata_read_dependencies / _write_dependencies  in  MAX_DEPENDENCIES each  dependency bitmaps.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  handshake to the scheduler.
- m_axis_tdata_owner_programID / _read_dependencies / _write_dependencies  out  64 / MAX_DEPENDENCIES / MAX_DEPENDENCIES  presented transaction.
- m_axis_tuser_retry_cnt  out  $clog2(MAX_RETRIES+1)  number of prior submissions of the presented transaction.
- m_axis_reject  in  1  qualified by an m_axis handshake in the same cycle: the scheduler dropped that transaction on conflict.
- abandon_valid  out  1  one-cycle pulse when a transaction is discarded.
- abandon_owner_programID  out  64  ID of the discarded transaction; valid with abandon_valid.
- retry_occupancy  out  $clog2(RETRY_DEPTH+1)  current FIFO fill.
- total_retries, total_abandoned, total_forwarded  out  32 each  saturating counters.

## Operation
- Output register: a single entry holding data, retry count and valid.
  - It reloads when empty or when handshaking this cycle (load_ok = !m_axis_tvalid || m_axis_tready).
- Source select on load_ok:
  - The FIFO head has priority when it is eligible: (cycle_ts − head_ts) mod 2^16 ≥ BACKOFF_CYCLES.
  - Otherwise a fresh transaction loads with retry count 0.
- cycle_ts is a free-running 16-bit counter; it wraps naturally.
- s_axis_tready = load_ok && !head_eligible && space_ok, where space_ok = (retry_occupancy < RETRY_DEPTH−1) || (retry_occupancy == RETRY_DEPTH−1 && !m_axis_tvalid).
  - This guarantees a slot for the in-flight transaction, so a push never overflows.
  - No combinational path exists from m_axis_reject to s_axis_tready.
- On a handshake with m_axis_reject=0: total_forwarded increments.
- On a handshake with m_axis_reject=1:
  - If retry count < MAX_RETRIES: push {data, count+1, cycle_ts}; total_retries increments.
  - Otherwise: no push; pulse abandon_valid with the owner ID; total_abandoned increments.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- FIFO order is strict. A non-eligible head blocks later entries; this is acceptable because entries enter in timestamp order.
- Ineligible head and no fresh input: the output register empties after its handshake.

## Timing
- Fresh transaction: accepted in cycle N, m_axis_tvalid in N+1.
- Reject: rejected at cycle R; the retry is presented no earlier than R+1+BACKOFF_CYCLES.
  - It is presented exactly then when the output register is free.
- m_axis data is stable while m_axis_tvalid=1 && !m_axis_tready.
- Reset values: m_axis_tvalid=0, abandon_valid=0, retry_occupancy=0, all counters=0, cycle_ts=0, all data outputs=0.
- Reset mid-operation discards all FIFO and output-register contents; nothing is abandoned or reported.
- Counters saturate at 2^32−1.

## Structure
- Package svm_sched_pkg:
  - txn_t struct: owner ID plus read and write bitmaps, parameterised by MAX_DEPENDENCIES.
  - retry_entry_t struct: txn_t, retry count, 16-bit timestamp.
  - TS_W=16 constant.
- Sub-module retry_fifo: synchronous FIFO of retry_entry_t.
  - Provides push, pop, head, and occupancy.
  - Wrap-around pointers, asynchronous reset.

## Test plan
- Forward path: 4 fresh transactions with IDs 1..4, m_axis_tready=1, no reject. Expect IDs 1..4 in order, one per cycle after 1-cycle latency, retry_cnt=0, total_forwarded=4.
- Single reject: ID 7 rejected at cycle R. Expect ID 7 re-presented at exactly R+17 with retry_cnt=1, total_retries=1.
  - A fresh ID 8 offered meanwhile goes out first.
- Abandon with MAX_RETRIES=2: ID 9 always rejected. Expect three submissions with retry_cnt 0, 1, 2, then abandon_valid with ID 9, total_abandoned=1, retry_occupancy=0.
- Full: RETRY_DEPTH=4, reject every transaction. Expect s_axis_tready=0 once occupancy reaches 3 with output valid, no entry lost, and occupancy never above 4.
- Wrap: run cycle_ts past 0xFFFF with a reject at ts=0xFFF8. Expect resubmission 16 cycles later, at ts=0x0008 or later.
- Reset mid-stream with 3 entries queued: assert rst_n=0. Expect m_axis_tvalid=0 and all counters and occupancy=0 immediately; no abandon pulse.
